alu_issue_stage: RTL and testbench

Decode/issue stage that produces the ALU's operand and control interface. It decodes an RV32 instruction and reads register operands. It registers srcA, srcB, imm_alu, alu_control and alu_src into an ID/EX pipeline register under a valid/ready handshake. It sits between fetch and the ALU/execute stage, which consumes the registered outputs.

---
 rtl/rv32_alu_pkg.sv | 26 ++
 rtl/alu_decode.sv | 94 +++++++++
 rtl/alu_issue_stage.sv | 133 +++++++++++++
 tb/tb_alu_issue_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_alu_pkg.sv
// Shared RV32 ALU issue constants: ALU operation codes, major opcodes and funct7 values.
package rv32_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 decode for the ALU subset: instruction word to ALU control,
// operand selection, immediate, write-back enable and illegal flag.
module alu_decode
  import rv32_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [3:0]      alu_control,
  output logic            alu_src,
  output logic [XLEN-1:0] imm,
  output logic            use_zero_a,
  output logic            reg_write,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       legal;
  logic       unused_rs1_field;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rd  = instr[11:7];
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    alu_control = ALU_ADD;
    alu_src     = 1'b0;
    imm         = '0;
    use_zero_a  = 1'b0;
    legal       = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          case (f3)
            F3_ADD:  alu_control = ALU_ADD;
            F3_SLL:  alu_control = ALU_SLL;
            F3_SLTU: alu_control = ALU_SLTU;
            F3_XOR:  alu_control = ALU_XOR;
            F3_OR:   alu_control = ALU_OR;
            F3_AND:  alu_control = ALU_AND;
            default: legal = 1'b0;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          legal       = 1'b1;
          alu_control = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        // SLLI carries a zero-extended shamt; every other supported form a sign-extended imm12
        legal   = 1'b1;
        alu_src = 1'b1;
        imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (f3)
          F3_ADD:  alu_control = ALU_ADD;
          F3_SLTU: alu_control = ALU_SLTU;
          F3_XOR:  alu_control = ALU_XOR;
          F3_OR:   alu_control = ALU_OR;
          F3_AND:  alu_control = ALU_AND;
          F3_SLL: begin
            alu_control = ALU_SLL;
            imm         = {{(XLEN-5){1'b0}}, instr[24:20]};
            if (f7 != F7_BASE) legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal       = 1'b1;
        alu_control = ALU_ADD;
        alu_src     = 1'b1;
        use_zero_a  = 1'b1;
        imm         = {{(XLEN-32){1'b0}}, instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    // Illegal instructions fall back to a harmless ADD on register operands
    if (!legal) begin
      alu_control = ALU_ADD;
      alu_src     = 1'b0;
      imm         = '0;
      use_zero_a  = 1'b0;
    end
  end

  assign illegal   = !legal;
  assign reg_write = legal && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// RV32 decode/issue stage: decodes, reads operands and registers the ALU interface
// into an ID/EX register under valid/ready. Optional counters: ALU_ISSUE_PERF_EN.
module alu_issue_stage
  import rv32_alu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] imm_alu,
  output logic [3:0]      alu_control,
  output logic            alu_src,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     issue_count,
  output logic [31:0]     stall_count
`endif
);

  logic [3:0]      ctl_p0;
  logic            src_p0;
  logic [XLEN-1:0] imm_p0;
  logic            zero_a_p0;
  logic            rw_p0;
  logic            ill_p0;
  logic            fire;

  logic            vld_p1;
  logic [XLEN-1:0] srca_p1;
  logic [XLEN-1:0] srcb_p1;
  logic [XLEN-1:0] imm_p1;
  logic [3:0]      ctl_p1;
  logic            src_p1;
  logic [4:0]      rd_p1;
  logic            rw_p1;
  logic            ill_p1;
  logic [XLEN-1:0] pc_p1;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_decode #(.XLEN(XLEN)) u_decode (
    .instr       (in_instr),
    .alu_control (ctl_p0),
    .alu_src     (src_p0),
    .imm         (imm_p0),
    .use_zero_a  (zero_a_p0),
    .reg_write   (rw_p0),
    .illegal     (ill_p0)
  );

  assign in_ready = !flush && (!vld_p1 || ex_ready);
  assign fire     = in_valid && in_ready;

  // ---- p0 -> p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      srca_p1 <= '0;
      srcb_p1 <= '0;
      imm_p1  <= '0;
      ctl_p1  <= ALU_ADD;
      src_p1  <= 1'b0;
      rd_p1   <= 5'd0;
      rw_p1   <= 1'b0;
      ill_p1  <= 1'b0;
      pc_p1   <= RESET_PC_TAG;
    end else begin
      if (flush)         vld_p1 <= 1'b0;
      else if (fire)     vld_p1 <= 1'b1;
      else if (ex_ready) vld_p1 <= 1'b0;
      if (fire) begin
        srca_p1 <= zero_a_p0 ? '0 : rs1_data;
        srcb_p1 <= rs2_data;
        imm_p1  <= imm_p0;
        ctl_p1  <= ctl_p0;
        src_p1  <= src_p0;
        rd_p1   <= in_instr[11:7];
        rw_p1   <= rw_p0;
        ill_p1  <= ill_p0;
        pc_p1   <= in_pc;
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign srcA         = srca_p1;
  assign srcB         = srcb_p1;
  assign imm_alu      = imm_p1;
  assign alu_control  = ctl_p1;
  assign alu_src      = src_p1;
  assign ex_rd        = rd_p1;
  assign ex_reg_write = rw_p1;
  assign ex_illegal   = ill_p1;
  assign ex_pc        = pc_p1;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt_p1;
  logic [31:0] stall_cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_p1 <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      if (fire) issue_cnt_p1 <= issue_cnt_p1 + 32'd1;
      if (!flush && vld_p1 && !ex_ready) stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
    end
  end

  assign issue_count = issue_cnt_p1;
  assign stall_count = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage against a mnemonic-level
// reference model of the decode rules and the valid/ready hold behaviour.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] srcA, srcB, imm_alu;
  logic [3:0]  alu_control;
  logic        alu_src;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_illegal;
  logic [31:0] ex_pc;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_count, stall_count;
  logic [31:0] m_issue, m_stall;
`endif

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .srcA(srcA), .srcB(srcB), .imm_alu(imm_alu),
    .alu_control(alu_control), .alu_src(alu_src), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
`ifdef ALU_ISSUE_PERF_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state: what the execute side should be seeing
  logic        m_valid;
  logic [31:0] m_srcA, m_srcB, m_imm, m_pc;
  logic [3:0]  m_ctl;
  logic        m_src, m_rw, m_ill;
  logic [4:0]  m_rd;

  logic [3:0] op_of [string];

  function automatic string mnemonic(input logic [31:0] ins);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    string r_names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string i_names [8] = '{"ADDI", "SLLI", "SLTI", "SLTIU", "XORI", "SRXI", "ORI", "ANDI"};
    if (opc == 7'h33) begin
      if (f7 == 7'h00) return r_names[f3];
      if (f7 == 7'h20) return (f3 == 3'd0) ? "SUB" : (f3 == 3'd5) ? "SRA" : "BAD";
      return "BAD";
    end
    if (opc == 7'h13) begin
      if (f3 == 3'd1 && f7 != 7'h00) return "BAD";
      return i_names[f3];
    end
    if (opc == 7'h37) return "LUI";
    return "OTHER";
  endfunction

  task automatic model_reset();
    m_valid = 0; m_srcA = 0; m_srcB = 0; m_imm = 0; m_ctl = 4'b0010;
    m_src = 0; m_rd = 0; m_rw = 0; m_ill = 0; m_pc = 32'h0;
`ifdef ALU_ISSUE_PERF_EN
    m_issue = 0; m_stall = 0;
`endif
  endtask

  task automatic model_load();
    string mn = mnemonic(in_instr);
    logic  legal = op_of.exists(mn);
    m_ill  = !legal;
    m_ctl  = legal ? op_of[mn] : 4'b0010;
    m_src  = legal && (in_instr[6:0] != 7'h33);
    if (!legal || in_instr[6:0] == 7'h33) m_imm = 0;
    else if (mn == "LUI")  m_imm = {in_instr[31:12], 12'h000};
    else if (mn == "SLLI") m_imm = {27'd0, in_instr[24:20]};
    else m_imm = {{20{in_instr[31]}}, in_instr[31:20]};
    m_srcA = (mn == "LUI") ? 32'd0 : rs1_data;
    m_srcB = rs2_data;
    m_rd   = in_instr[11:7];
    m_rw   = legal && (in_instr[11:7] != 5'd0);
    m_pc   = in_pc;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".srcA"}, srcA, m_srcA);
    chk({tag, ".srcB"}, srcB, m_srcB);
    chk({tag, ".imm_alu"}, imm_alu, m_imm);
    chk({tag, ".alu_control"}, 32'(alu_control), 32'(m_ctl));
    chk({tag, ".alu_src"}, 32'(alu_src), 32'(m_src));
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m_rd));
    chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m_rw));
    chk({tag, ".ex_illegal"}, 32'(ex_illegal), 32'(m_ill));
    chk({tag, ".ex_pc"}, ex_pc, m_pc);
`ifdef ALU_ISSUE_PERF_EN
    chk({tag, ".issue_count"}, issue_count, m_issue);
    chk({tag, ".stall_count"}, stall_count, m_stall);
`endif
  endtask

  // One clock: check in_ready and register addresses, clock, advance model, compare.
  task automatic cycle(input string tag);
    logic exp_ready, do_fire;
    #1;
    exp_ready = !flush && (!m_valid || ex_ready);
    do_fire   = in_valid && exp_ready;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    chk({tag, ".rs1_addr"}, 32'(rs1_addr), 32'(in_instr[19:15]));
    chk({tag, ".rs2_addr"}, 32'(rs2_addr), 32'(in_instr[24:20]));
`ifdef ALU_ISSUE_PERF_EN
    if (do_fire) m_issue++;
    if (!flush && m_valid && !ex_ready) m_stall++;
`endif
    if (do_fire) model_load();
    if (flush) m_valid = 0;
    else if (do_fire) m_valid = 1;
    else if (ex_ready) m_valid = 0;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 7);
    if (sel <= 2) begin
      w[6:0] = 7'h33;
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h00;
        default: ;
      endcase
    end else if (sel <= 5) begin
      w[6:0] = 7'h13;
      if ($urandom_range(0, 1) == 1) w[31:25] = 7'h00;
    end else if (sel == 6) begin
      w[6:0] = 7'h37;
    end
    return w;
  endfunction

  initial begin
    op_of["ADD"] = 4'b0010;  op_of["SLL"] = 4'b0011;  op_of["SLTU"] = 4'b0100;
    op_of["XOR"] = 4'b0101;  op_of["OR"] = 4'b0001;   op_of["AND"] = 4'b0000;
    op_of["SUB"] = 4'b0110;  op_of["ADDI"] = 4'b0010; op_of["SLTIU"] = 4'b0100;
    op_of["XORI"] = 4'b0101; op_of["ORI"] = 4'b0001;  op_of["ANDI"] = 4'b0000;
    op_of["SLLI"] = 4'b0011; op_of["LUI"] = 4'b0010;

    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
    flush = 0; ex_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1;

    // ADD x3,x1,x2
    in_valid = 1; in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    rs1_data = 5; rs2_data = 7; in_pc = 32'h100;
    cycle("add");
    chk("add.srcA_lit", srcA, 32'd5);
    chk("add.srcB_lit", srcB, 32'd7);
    chk("add.ctl_lit", 32'(alu_control), 32'h2);
    chk("add.rw_lit", 32'(ex_reg_write), 32'd1);

    // ADDI x1,x0,-1
    in_instr = {12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13}; in_pc = 32'h104;
    cycle("addi");
    chk("addi.imm_lit", imm_alu, 32'hFFFF_FFFF);
    chk("addi.src_lit", 32'(alu_src), 32'd1);

    // LUI x5,0x12345
    in_instr = {20'h12345, 5'd5, 7'h37}; in_pc = 32'h108; rs1_data = 32'hDEAD_BEEF;
    cycle("lui");
    chk("lui.srcA_lit", srcA, 32'd0);
    chk("lui.imm_lit", imm_alu, 32'h1234_5000);

    // SUB x4,x1,x2, then back-pressure with a waiting instruction
    in_instr = r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4); in_pc = 32'h10C;
    rs1_data = 9; rs2_data = 4;
    cycle("sub");
    ex_ready = 0; in_instr = r_type(7'h00, 5'd6, 5'd7, 3'd4, 5'd8); in_pc = 32'h110;
    rs1_data = 32'h55; rs2_data = 32'hAA;
    for (int i = 0; i < 3; i++) cycle("hold");
    chk("hold.ctl_lit", 32'(alu_control), 32'h6);
    ex_ready = 1;
    cycle("b2b");
    chk("b2b.ctl_lit", 32'(alu_control), 32'h5);

    // flush with a held instruction and a new one offered
    ex_ready = 0; flush = 1; in_instr = r_type(7'h00, 5'd1, 5'd1, 3'd7, 5'd9); in_pc = 32'h114;
    cycle("flush");
    chk("flush.valid_lit", 32'(ex_valid), 32'd0);
    chk("flush.ctl_lit", 32'(alu_control), 32'h5);
    flush = 0; ex_ready = 1;

    // SRA x2,x1,x1 (illegal) then ADD x0,x1,x2
    in_instr = r_type(7'h20, 5'd1, 5'd1, 3'd5, 5'd2); in_pc = 32'h118;
    cycle("sra");
    chk("sra.ill_lit", 32'(ex_illegal), 32'd1);
    chk("sra.rw_lit", 32'(ex_reg_write), 32'd0);
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0); in_pc = 32'h11C;
    cycle("add_x0");
    chk("add_x0.rw_lit", 32'(ex_reg_write), 32'd0);
    chk("add_x0.ill_lit", 32'(ex_illegal), 32'd0);

    // asynchronous reset while an instruction is held
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd12); in_pc = 32'h120; ex_ready = 0;
    cycle("pre_rst");
    #3 rst_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    in_valid = 0; ex_ready = 1;
    #3 rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      in_instr = rand_instr();
      in_pc    = $urandom;
      rs1_data = $urandom;
      rs2_data = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
